down_count_ctrl: RTL and testbench

Sequencing controller for a WIDTH-bit synchronous down-counter datapath. Loads a programmable start value, runs the counter to zero, and flags terminal count. Supports one-shot and auto-reload modes, hold and abort. Used as a programmable interval timer or event-delay generator beside the counter blocks.

---
 rtl/down_count_ctrl_pkg.sv | 15 +
 rtl/down_counter_dp.sv | 43 ++++
 rtl/down_count_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_down_count_ctrl.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/down_count_ctrl_pkg.sv
// down_count_ctrl_pkg
// Shared definitions for the down-count controller slice: FSM state
// encoding and default widths for the counter and the optional prescaler.
package down_count_ctrl_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_PRE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2
    } state_t;

endpackage

// File: rtl/down_counter_dp.sv
// down_counter_dp
// WIDTH-bit down-counter register driven by the sequencing controller.
// Command priority: clr > load > dec.
//
// Ports:
//   clk      system clock, state changes on posedge
//   rst      synchronous active-high reset, clears q
//   clr      synchronous clear to zero
//   load     load q from load_val
//   load_val value taken on load
//   dec      decrement q by one
//   q        current counter value (registered)
module down_counter_dp #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             dec,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] q_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            q_reg <= '0;
        end else if (clr) begin
            q_reg <= '0;
        end else if (load) begin
            q_reg <= load_val;
        end else if (dec && (q_reg != '0)) begin
            // The zero guard keeps the register from wrapping even if a
            // stray dec arrives; the controller never asks for one at zero.
            q_reg <= q_reg - WIDTH'(1);
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/down_count_ctrl.sv
// down_count_ctrl
// Sequencing controller for a WIDTH-bit down-counter: loads a start value,
// counts to zero, pulses done at terminal count. One-shot or auto-reload,
// with hold and abort.
//
// Optional feature (compile-time macro PRESCALE_EN): adds a prescale input;
// the counter then advances once every prescale+1 clocks.
//
// Ports:
//   clk          system clock
//   rst          synchronous active-high reset
//   start        launch a sequence (only looked at in IDLE)
//   stop         abort the sequence, back to IDLE with count=0
//   hold         freeze the count while high
//   auto_reload  1 = repeat at terminal count, 0 = one-shot (captured at start)
//   load_val     start value (captured at start)
//   prescale     tick divider, PRESCALE_EN builds only (captured at start)
//   count        current counter value
//   busy         high in RUN or HOLD
//   done         one-cycle registered pulse at terminal count
module down_count_ctrl
    import down_count_ctrl_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int PRE_W = DEF_PRE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_val,
`ifdef PRESCALE_EN
    input  logic [PRE_W-1:0] prescale,
`endif
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             done
);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] reload_reg, reload_next;
    logic             mode_reg, mode_next;
    logic             done_reg, done_next;

    logic             dp_clr;
    logic             dp_load;
    logic             dp_dec;
    logic [WIDTH-1:0] dp_load_val;
    logic             tick;

`ifdef PRESCALE_EN
    logic [PRE_W-1:0] pre_cnt_reg, pre_cnt_next;
    logic [PRE_W-1:0] pre_val_reg, pre_val_next;

    assign tick = (pre_cnt_reg == pre_val_reg);

    // Prescaler runs only while actively counting. It is held at zero in
    // IDLE (so a start always begins a fresh interval), frozen while hold
    // is high, and restarted when leaving HOLD.
    always_comb begin
        pre_cnt_next = pre_cnt_reg;
        pre_val_next = pre_val_reg;
        if (state_reg == IDLE || stop) begin
            pre_cnt_next = '0;
            if (state_reg == IDLE && !stop && start) begin
                pre_val_next = prescale;
            end
        end else if (hold) begin
            pre_cnt_next = pre_cnt_reg;
        end else if (state_reg == HOLD || tick) begin
            pre_cnt_next = '0;
        end else begin
            pre_cnt_next = pre_cnt_reg + PRE_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_reg <= '0;
            pre_val_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_next;
            pre_val_reg <= pre_val_next;
        end
    end
`else
    assign tick = 1'b1;
`endif

    // FSM next-state, capture registers and datapath commands.
    always_comb begin
        state_next  = state_reg;
        reload_next = reload_reg;
        mode_next   = mode_reg;
        done_next   = 1'b0;
        dp_clr      = 1'b0;
        dp_load     = 1'b0;
        dp_dec      = 1'b0;
        dp_load_val = reload_reg;

        case (state_reg)
            IDLE: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (start) begin
                    if (load_val != '0) begin
                        reload_next = load_val;
                        mode_next   = auto_reload;
                        dp_load     = 1'b1;
                        dp_load_val = load_val;
                        state_next  = RUN;
                    end else begin
                        // Zero-length run: report completion immediately.
                        done_next = 1'b1;
                    end
                end
            end

            RUN, HOLD: begin
                if (stop) begin
                    dp_clr     = 1'b1;
                    state_next = IDLE;
                end else if (hold) begin
                    state_next = HOLD;
                end else begin
                    // Leaving HOLD is treated as an ordinary counting cycle,
                    // so the extra delay equals the number of held cycles.
                    state_next = RUN;
                    if (tick) begin
                        if (count == WIDTH'(1)) begin
                            done_next = 1'b1;
                            if (mode_reg) begin
                                dp_load = 1'b1;
                            end else begin
                                dp_clr     = 1'b1;
                                state_next = IDLE;
                            end
                        end else begin
                            dp_dec = 1'b1;
                        end
                    end
                end
            end

            default: begin
                dp_clr     = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            reload_reg <= '0;
            mode_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            reload_reg <= reload_next;
            mode_reg   <= mode_next;
            done_reg   <= done_next;
        end
    end

    down_counter_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .clr      (dp_clr),
        .load     (dp_load),
        .load_val (dp_load_val),
        .dec      (dp_dec),
        .q        (count)
    );

    assign busy = (state_reg != IDLE);
    assign done = done_reg;

endmodule

// File: tb/tb_down_count_ctrl.sv
// tb_down_count_ctrl
// Directed bench for down_count_ctrl. Each step drives inputs, pushes the
// expected post-edge outputs to a scoreboard queue, then pops and compares
// them one time unit after the clock edge.
module tb_down_count_ctrl;

    localparam int WIDTH = 4;
    localparam int PRE_W = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             stop;
    logic             hold;
    logic             auto_reload;
    logic [WIDTH-1:0] load_val;
    logic [PRE_W-1:0] prescale;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             done;

    typedef struct {
        logic [WIDTH-1:0] count;
        logic             busy;
        logic             done;
    } exp_t;

    exp_t exp_q[$];
    int   total_cnt = 0;
    int   pass_cnt  = 0;
    int   step_no   = 0;

    always #5 clk = ~clk;

    down_count_ctrl #(
        .WIDTH (WIDTH),
        .PRE_W (PRE_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stop        (stop),
        .hold        (hold),
        .auto_reload (auto_reload),
        .load_val    (load_val),
`ifdef PRESCALE_EN
        .prescale    (prescale),
`endif
        .count       (count),
        .busy        (busy),
        .done        (done)
    );

    // Drive one cycle of inputs, queue the expected result, clock, compare.
    task automatic step(input string tag, input logic st, input logic sp,
                        input logic hd, input logic ar, input int lv,
                        input int e_count, input logic e_busy, input logic e_done);
        exp_t e;
        exp_t got;
        start       = st;
        stop        = sp;
        hold        = hd;
        auto_reload = ar;
        load_val    = WIDTH'(lv);
        e.count     = WIDTH'(e_count);
        e.busy      = e_busy;
        e.done      = e_done;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        step_no++;
        got = exp_q.pop_front();
        $display("step %0d %s: count=%0d busy=%0b done=%0b (exp %0d/%0b/%0b)",
                 step_no, tag, count, busy, done, got.count, got.busy, got.done);
        total_cnt++;
        assert (count === got.count) pass_cnt++;
        else $error("FAIL %s step %0d count: got %0d expected %0d", tag, step_no, count, got.count);
        total_cnt++;
        assert (busy === got.busy) pass_cnt++;
        else $error("FAIL %s step %0d busy: got %0b expected %0b", tag, step_no, busy, got.busy);
        total_cnt++;
        assert (done === got.done) pass_cnt++;
        else $error("FAIL %s step %0d done: got %0b expected %0b", tag, step_no, done, got.done);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; hold = 1'b0;
        auto_reload = 1'b0; load_val = '0; prescale = '0;

        // Reset dominates a simultaneous start.
        step("reset", 1, 0, 0, 0, 5, 0, 0, 0);
        step("reset", 1, 0, 0, 0, 5, 0, 0, 0);
        rst = 1'b0;
        step("idle", 0, 0, 0, 0, 0, 0, 0, 0);

        // One-shot of 5.
        step("oneshot5", 1, 0, 0, 0, 5, 5, 1, 0);
        step("oneshot5", 0, 0, 0, 0, 5, 4, 1, 0);
        step("oneshot5", 0, 0, 0, 0, 5, 3, 1, 0);
        step("oneshot5", 0, 0, 0, 0, 5, 2, 1, 0);
        step("oneshot5", 0, 0, 0, 0, 5, 1, 1, 0);
        step("oneshot5", 0, 0, 0, 0, 5, 0, 0, 1);
        // Back-to-back start right after done.
        step("b2b", 1, 0, 0, 0, 2, 2, 1, 0);
        step("b2b", 0, 0, 0, 0, 2, 1, 1, 0);
        step("b2b", 0, 0, 0, 0, 2, 0, 0, 1);
        step("b2b", 0, 0, 0, 0, 2, 0, 0, 0);

        // One-shot of 1.
        step("oneshot1", 1, 0, 0, 0, 1, 1, 1, 0);
        step("oneshot1", 0, 0, 0, 0, 1, 0, 0, 1);

        // Auto-reload of 3, with ignored start/load_val/mode changes, then stop.
        step("reload3", 1, 0, 0, 1, 3, 3, 1, 0);
        step("reload3", 0, 0, 0, 0, 9, 2, 1, 0);
        step("reload3", 0, 0, 0, 0, 9, 1, 1, 0);
        step("reload3", 0, 0, 0, 0, 9, 3, 1, 1);
        step("busy_start", 1, 0, 0, 0, 9, 2, 1, 0);
        step("reload3", 0, 0, 0, 0, 7, 1, 1, 0);
        step("reload3", 0, 0, 0, 0, 7, 3, 1, 1);
        step("reload3", 0, 0, 0, 0, 7, 2, 1, 0);
        step("reload_stop", 0, 1, 0, 0, 7, 0, 0, 0);
        step("reload_stop", 0, 0, 0, 0, 7, 0, 0, 0);

        // Auto-reload of 1: done every cycle, count never shows 0.
        step("reload1", 1, 0, 0, 1, 1, 1, 1, 0);
        step("reload1", 0, 0, 0, 0, 1, 1, 1, 1);
        step("reload1", 0, 0, 0, 0, 1, 1, 1, 1);
        step("reload1", 0, 1, 0, 0, 1, 0, 0, 0);

        // Hold for 3 cycles at count=2: done 3 cycles later than unheld.
        step("hold4", 1, 0, 0, 0, 4, 4, 1, 0);
        step("hold4", 0, 0, 0, 0, 4, 3, 1, 0);
        step("hold4", 0, 0, 0, 0, 4, 2, 1, 0);
        step("hold4", 0, 0, 1, 0, 4, 2, 1, 0);
        step("hold4", 0, 0, 1, 0, 4, 2, 1, 0);
        step("hold4", 0, 0, 1, 0, 4, 2, 1, 0);
        step("hold4", 0, 0, 0, 0, 4, 1, 1, 0);
        step("hold4", 0, 0, 0, 0, 4, 0, 0, 1);

        // Stop while held.
        step("hold_stop", 1, 0, 0, 0, 3, 3, 1, 0);
        step("hold_stop", 0, 0, 1, 0, 3, 3, 1, 0);
        step("hold_stop", 0, 1, 1, 0, 3, 0, 0, 0);

        // Zero-length run.
        step("zero_len", 1, 0, 0, 0, 0, 0, 0, 1);
        step("zero_len", 0, 0, 0, 0, 0, 0, 0, 0);

        // start and stop together in IDLE: no launch.
        step("start_stop", 1, 1, 0, 0, 5, 0, 0, 0);
        step("start_stop", 0, 0, 0, 0, 5, 0, 0, 0);

        // Stop on the terminal cycle: no done.
        step("stop_term", 1, 0, 0, 0, 2, 2, 1, 0);
        step("stop_term", 0, 0, 0, 0, 2, 1, 1, 0);
        step("stop_term", 0, 1, 0, 0, 2, 0, 0, 0);
        step("stop_term", 0, 0, 0, 0, 2, 0, 0, 0);

`ifdef PRESCALE_EN
        // prescale=2, load 2: one decrement every 3 clocks, done 6 after start.
        prescale = PRE_W'(2);
        step("prescale", 1, 0, 0, 0, 2, 2, 1, 0);
        prescale = '0;
        step("prescale", 0, 0, 0, 0, 2, 2, 1, 0);
        step("prescale", 0, 0, 0, 0, 2, 2, 1, 0);
        step("prescale", 0, 0, 0, 0, 2, 1, 1, 0);
        step("prescale", 0, 0, 0, 0, 2, 1, 1, 0);
        step("prescale", 0, 0, 0, 0, 2, 1, 1, 0);
        step("prescale", 0, 0, 0, 0, 2, 0, 0, 1);
`endif

        total_cnt++;
        assert (exp_q.size() == 0) pass_cnt++;
        else $error("FAIL scoreboard_drain: got %0d entries left expected 0", exp_q.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
